// File: rtl/disp_pkg.sv
// Shared display-controller package: direction encoding and an elaboration-time
// ceil(log2) helper used to size counters across the display blocks.
package disp_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of one mod_counter stage; the counter is the slave,
// whoever drives enable/load/clear is the master.
interface mod_counter_if #(
  parameter int WIDTH = 4
) ();

  logic             enable;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             cascade_en;
  logic             wrap;

  modport master (
    output enable, up_dn, clear, load, load_val,
    input  count, tc, cascade_en, wrap
  );

  modport slave (
    input  enable, up_dn, clear, load, load_val,
    output count, tc, cascade_en, wrap
  );

endinterface

// File: rtl/mod_counter_prescale.sv
// Enable prescaler: turns every PRESCALE-th qualifying enable into one step.
// With PRESCALE=1 it degenerates to a gated wire and holds no state.
module mod_counter_prescale
  import disp_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sync_clr,
  output logic step
);

  if (PRESCALE == 1) begin : g_passthru
    logic unused_inputs;
    assign unused_inputs = ^{clk, sync_clr};
    // Gating with rst_n keeps cascade outputs quiet while the chain is in reset.
    assign step = enable && rst_n;
  end else begin : g_count
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;

    assign step = enable && rst_n && (pre_cnt_q == PRE_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (sync_clr || step) begin
        pre_cnt_d = '0;
      end else if (enable) begin
        pre_cnt_d = pre_cnt_q + PW'(1);
      end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_d;
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, load/clear, wrap or saturate mode and
// a combinational cascade enable for chaining digit/divider stages.
module mod_counter
  import disp_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input logic         clk,
  input logic         rst_n,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST      = WIDTH'(MODULUS - 1);
  localparam bit               WRAP_MODE = (SATURATE == 0);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             step;
  logic             tc;
  logic             wrap_event;

  mod_counter_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (bus.enable),
    .sync_clr (bus.clear || bus.load),
    .step     (step)
  );

  // Terminal value depends on the direction currently requested, not the last step's.
  assign tc = (bus.up_dn == DIR_UP) ? (count_q == LAST) : (count_q == '0);

  assign wrap_event = WRAP_MODE && step && tc && !bus.clear && !bus.load;

  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_event;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = (bus.load_val > LAST) ? LAST : bus.load_val;
    end else if (step) begin
      if (tc) begin
        if (WRAP_MODE) begin
          count_d = (bus.up_dn == DIR_DOWN) ? LAST : '0;
        end
      end else if (bus.up_dn == DIR_UP) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = tc;
  assign bus.cascade_en = wrap_event;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three configurations driven in lockstep
// against an arithmetic reference model, plus a two-stage units/tens chain.
module tb_mod_counter;

  localparam int M = 10;
  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mod_counter_if #(.WIDTH(4)) a_if ();
  mod_counter_if #(.WIDTH(4)) b_if ();
  mod_counter_if #(.WIDTH(4)) c_if ();
  mod_counter_if #(.WIDTH(4)) u_if ();
  mod_counter_if #(.WIDTH(4)) t_if ();

  mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1), .SATURATE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(3), .SATURATE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1), .SATURATE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1), .SATURATE(0)) u_units (.clk(clk), .rst_n(rst_n), .bus(u_if));
  mod_counter #(.WIDTH(4), .MODULUS(M), .PRESCALE(1), .SATURATE(0)) u_tens  (.clk(clk), .rst_n(rst_n), .bus(t_if));

  assign t_if.enable = u_if.cascade_en;

  // Reference model: configuration table and abstract state per lockstep DUT.
  int cfg_pre [N] = '{1, 3, 1};
  bit cfg_sat [N] = '{1'b0, 1'b0, 1'b1};
  int mdl_cnt [N];
  int mdl_pre [N];
  bit mdl_wrap[N];
  bit in_reset;

  logic [3:0] obs_cnt [N];
  logic       obs_tc  [N];
  logic       obs_casc[N];
  logic       obs_wrap[N];

  assign obs_cnt[0] = a_if.count;  assign obs_tc[0] = a_if.tc;
  assign obs_cnt[1] = b_if.count;  assign obs_tc[1] = b_if.tc;
  assign obs_cnt[2] = c_if.count;  assign obs_tc[2] = c_if.tc;
  assign obs_casc[0] = a_if.cascade_en;  assign obs_wrap[0] = a_if.wrap;
  assign obs_casc[1] = b_if.cascade_en;  assign obs_wrap[1] = b_if.wrap;
  assign obs_casc[2] = c_if.cascade_en;  assign obs_wrap[2] = c_if.wrap;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic bit tc_exp(input int k, input bit ud);
    return ud ? (mdl_cnt[k] == M - 1) : (mdl_cnt[k] == 0);
  endfunction

  function automatic bit step_exp(input int k, input bit en);
    return !in_reset && en && (mdl_pre[k] == cfg_pre[k] - 1);
  endfunction

  function automatic bit casc_exp(input int k, input bit en, input bit ud, input bit clr, input bit ld);
    return step_exp(k, en) && tc_exp(k, ud) && !clr && !ld && !cfg_sat[k];
  endfunction

  task automatic check_all(input bit en, input bit ud, input bit clr, input bit ld);
    for (int k = 0; k < N; k++) begin
      check($sformatf("count%0d", k), obs_cnt[k],  mdl_cnt[k]);
      check($sformatf("tc%0d", k),    obs_tc[k],   tc_exp(k, ud));
      check($sformatf("casc%0d", k),  obs_casc[k], casc_exp(k, en, ud, clr, ld));
      check($sformatf("wrap%0d", k),  obs_wrap[k], mdl_wrap[k]);
    end
  endtask

  task automatic model_step(input bit en, input bit ud, input bit clr, input bit ld, input int lv);
    if (in_reset) return;
    for (int k = 0; k < N; k++) begin
      bit stp;
      stp = step_exp(k, en);
      mdl_wrap[k] = casc_exp(k, en, ud, clr, ld);
      if (clr) begin
        mdl_cnt[k] = 0;
        mdl_pre[k] = 0;
      end else if (ld) begin
        mdl_cnt[k] = (lv > M - 1) ? M - 1 : lv;
        mdl_pre[k] = 0;
      end else if (stp) begin
        mdl_pre[k] = 0;
        if (!cfg_sat[k])   mdl_cnt[k] = (mdl_cnt[k] + (ud ? 1 : M - 1)) % M;
        else if (ud)       mdl_cnt[k] = (mdl_cnt[k] + 1 > M - 1) ? M - 1 : mdl_cnt[k] + 1;
        else               mdl_cnt[k] = (mdl_cnt[k] == 0) ? 0 : mdl_cnt[k] - 1;
      end else if (en) begin
        mdl_pre[k]++;
      end
    end
  endtask

  // One clock: drive on the falling edge, check settled outputs, advance model.
  task automatic cycle(input bit rst, input bit en, input bit ud, input bit clr, input bit ld,
                       input logic [3:0] lv, input bit ch);
    @(negedge clk);
    rst_n = rst;
    a_if.enable = en;  a_if.up_dn = ud;  a_if.clear = clr;  a_if.load = ld;  a_if.load_val = lv;
    b_if.enable = en;  b_if.up_dn = ud;  b_if.clear = clr;  b_if.load = ld;  b_if.load_val = lv;
    c_if.enable = en;  c_if.up_dn = ud;  c_if.clear = clr;  c_if.load = ld;  c_if.load_val = lv;
    u_if.enable = ch;
    in_reset = !rst;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        mdl_cnt[k] = 0;  mdl_pre[k] = 0;  mdl_wrap[k] = 1'b0;
      end
    end
    #1;
    check_all(en, ud, clr, ld);
    model_step(en, ud, clr, ld, int'(lv));
  endtask

  initial begin
    bit ud_r;
    u_if.up_dn = 1'b1;  u_if.clear = 1'b0;  u_if.load = 1'b0;  u_if.load_val = '0;  u_if.enable = 1'b0;
    t_if.up_dn = 1'b1;  t_if.clear = 1'b0;  t_if.load = 1'b0;  t_if.load_val = '0;

    // Reset state, then enable+down while still in reset: tc high, cascade quiet.
    cycle(0, 0, 1, 0, 0, 4'd0, 0);
    cycle(0, 0, 1, 0, 0, 4'd0, 0);
    cycle(0, 1, 0, 0, 0, 4'd0, 0);

    // Count up with enable held through a full wrap.
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("up_wrap_a_count", a_if.count, 0);
    check("up_wrap_a_pulse", a_if.wrap, 1);
    check("up_sat_c_count", c_if.count, 9);

    // Prescale 3: nine contiguous enables, then nine interleaved enables.
    cycle(1, 0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 1, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("pre3_contig_b", b_if.count, 3);
    cycle(1, 0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 18; i++) cycle(1, (i % 2) == 0, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("pre3_toggle_b", b_if.count, 3);

    // Down from reset: wrap to 9, saturating build holds at 0.
    cycle(0, 0, 1, 0, 0, 4'd0, 0);
    cycle(1, 1, 0, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("down_wrap_a", a_if.count, 9);
    check("down_wrap_a_pulse", a_if.wrap, 1);
    check("down_sat_c", c_if.count, 0);

    // Load clamps; clear beats load and a pending wrap step.
    cycle(1, 0, 1, 0, 1, 4'd12, 0);
    @(posedge clk); #1;
    check("load_clamp_a", a_if.count, 9);
    cycle(1, 1, 1, 1, 1, 4'd5, 0);
    @(posedge clk); #1;
    check("clr_prio_a_count", a_if.count, 0);
    check("clr_prio_a_wrap", a_if.wrap, 0);

    // Units/tens chain: 99 steps, then the 100th rolls both over.
    for (int i = 0; i < 99; i++) cycle(1, 0, 1, 0, 0, 4'd0, 1);
    @(posedge clk); #1;
    check("chain99_units", u_if.count, 9);
    check("chain99_tens", t_if.count, 9);
    check("chain99_tens_casc", t_if.cascade_en, 1);
    cycle(1, 0, 1, 0, 0, 4'd0, 1);
    @(posedge clk); #1;
    check("chain100_units", u_if.count, 0);
    check("chain100_tens", t_if.count, 0);
    check("chain100_tens_wrap", t_if.wrap, 1);
    cycle(1, 0, 1, 0, 0, 4'd0, 0);

    // Asynchronous reset mid-count with b at count=7, pre_cnt=1.
    cycle(1, 0, 1, 0, 1, 4'd7, 0);
    cycle(1, 1, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #2;
    check("async_pre_b", b_if.count, 7);
    rst_n = 1'b0;
    #1;
    check("async_b_count", b_if.count, 0);
    check("async_a_count", a_if.count, 0);
    check("async_b_wrap", b_if.wrap, 0);
    cycle(0, 1, 0, 0, 0, 4'd0, 0);
    cycle(1, 1, 1, 0, 0, 4'd0, 0);
    cycle(1, 1, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("release_b_two", b_if.count, 0);
    cycle(1, 1, 1, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    check("release_b_three", b_if.count, 1);

    // Randomized traffic with direction runs, rare clear/load/reset.
    ud_r = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ud_r = ~ud_r;
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, ud_r,
            $urandom_range(0, 31) == 0, $urandom_range(0, 19) == 0,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
